// File: rtl/conv_frame_packer.sv
// conv_frame_packer: collects a raster stream of CH-channel pixels (one per
// beat) into a flattened H x W x CH frame bus, then presents that frame with
// out_vld held for SEND_CYCLES cycles while the contents stay frozen.
// Channel c, pixel p (raster order, column fastest) lives at bit offset
// (c*H*W + p)*DW of conv_lin.
module conv_frame_packer #(
  parameter int DW          = 8,
  parameter int H           = 6,
  parameter int W           = 6,
  parameter int CH          = 3,
  parameter int SEND_CYCLES = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic                   in_sof,
  input  logic [CH*DW-1:0]       in_data,
  input  logic                   err_clr,
  output logic [H*W*CH*DW-1:0]   conv_lin,
  output logic                   out_vld,
  output logic                   sof_err
);

  localparam int NPIX = H * W;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  pix_cnt;
  logic [5:0]  pix_cnt_nx;
  logic [3:0]  snd_cnt;
  logic [3:0]  snd_cnt_nx;
  logic        accept;
  logic        resync;
  logic        last_beat;
  logic [5:0]  slot;

  // Handshake decode: which slot this beat lands in, and whether it is a resync
  // (SOF seen mid-frame) or the final beat of the frame.
  always_comb begin
    accept    = in_vld & in_rdy;
    resync    = accept & in_sof & (pix_cnt != 6'd0);
    slot      = resync ? 6'd0 : pix_cnt;
    last_beat = accept & ~resync & (pix_cnt == 6'(NPIX - 1));
  end

  // Next-state and counter logic for the FILL/SEND sequencer.
  always_comb begin
    state_nx   = state;
    pix_cnt_nx = pix_cnt;
    snd_cnt_nx = snd_cnt;
    case (state)
      FILL: begin
        if (resync) begin
          pix_cnt_nx = 6'd1;
        end else if (last_beat) begin
          pix_cnt_nx = 6'd0;
          snd_cnt_nx = 4'd0;
          state_nx   = SEND;
        end else if (accept) begin
          pix_cnt_nx = pix_cnt + 6'd1;
        end else begin
          pix_cnt_nx = pix_cnt;
        end
      end
      SEND: begin
        if (snd_cnt == 4'(SEND_CYCLES - 1)) begin
          snd_cnt_nx = 4'd0;
          state_nx   = FILL;
        end else begin
          snd_cnt_nx = snd_cnt + 4'd1;
        end
      end
      default: begin
        state_nx   = FILL;
        pix_cnt_nx = 6'd0;
        snd_cnt_nx = 4'd0;
      end
    endcase
  end

  // State, counters and the handshake outputs, all registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      pix_cnt <= 6'd0;
      snd_cnt <= 4'd0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
    end else begin
      state   <= state_nx;
      pix_cnt <= pix_cnt_nx;
      snd_cnt <= snd_cnt_nx;
      in_rdy  <= (state_nx == FILL);
      out_vld <= (state_nx == SEND);
    end
  end

  // Frame storage: only the addressed slot of each channel is written on a beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_lin <= '0;
    end else if (accept) begin
      for (int p = 0; p < NPIX; p++) begin
        for (int c = 0; c < CH; c++) begin
          if (slot == 6'(p)) begin
            conv_lin[(c*NPIX + p)*DW +: DW] <= in_data[c*DW +: DW];
          end
        end
      end
    end
  end

  // Sticky SOF error flag; a new error in the clearing cycle takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_err <= 1'b0;
    end else if (resync) begin
      sof_err <= 1'b1;
    end else if (err_clr) begin
      sof_err <= 1'b0;
    end else begin
      sof_err <= sof_err;
    end
  end

endmodule

// File: doc/conv_frame_packer.md
Name: conv_frame_packer

Overview:
- Producer side of the pool stage's frame interface.
- Accepts conv-engine results as a serial raster stream of one pixel per beat, 3 channels per beat, with a valid/ready handshake.
- Packs 36 beats into the flattened 6x6x3x8 frame bus that the pool stage consumes.
- Presents the completed frame with its valid held high for exactly the 9 pool window cycles, with the frame data stable throughout.

Parameters:
DW, 8, bits per pixel per channel
H, 6, frame rows
W, 6, frame columns
CH, 3, channels per beat/frame
SEND_CYCLES, 9, cycles out_vld is held per frame ((H/2)*(W/2))

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_vld  input  1  input beat valid
in_rdy  output  1  packer can accept a beat
in_sof  input  1  beat is pixel (0,0) of a frame
in_data  input  CH*DW  pixel; channel c at [c*DW+DW-1 : c*DW] (D1 = c0, low byte)
err_clr  input  1  synchronous clear of sof_err
conv_lin  output  H*W*CH*DW  packed frame
out_vld  output  1  frame valid, held for SEND_CYCLES cycles
sof_err  output  1  sticky: in_sof received mid-frame

Behaviour:
- Packing layout:
  - Pixel index p = r*W + col, raster order, col fastest.
  - Channel c, pixel p lives at conv_lin bit offset (c*H*W + p)*DW, DW bits wide.
- State machine (registered), two states:
  - FILL: in_rdy=1, out_vld=0.
  - SEND: in_rdy=0, out_vld=1.
- Counters:
  - pix_cnt: 0..H*W-1, 6 bits.
  - snd_cnt: 0..SEND_CYCLES-1, 4 bits.
- Accept rule: a beat is accepted when in_vld & in_rdy.
  - The accepted in_data is written into slot pix_cnt on that edge, and pix_cnt increments.
  - No other conv_lin bits change.
- FILL -> SEND: on acceptance of the beat with pix_cnt == H*W-1.
  - pix_cnt -> 0 and snd_cnt -> 0.
- SEND: out_vld=1 and conv_lin is frozen (no writes).
  - snd_cnt increments each cycle.
  - When snd_cnt == SEND_CYCLES-1: -> FILL, snd_cnt -> 0.
- Latency: if the last beat is accepted at edge T:
  - out_vld=1 and in_rdy=0 for exactly the 9 cycles after T.
  - in_rdy=1 again on the 10th cycle, so back-to-back frames are possible.
- conv_lin during FILL:
  - Partially updated; undefined for the consumer.
  - Consumers only sample while out_vld=1.
  - Slots not yet rewritten keep the previous frame's values.
- in_vld while in SEND: ignored (in_rdy=0); the upstream holds its beat.
- in_sof handling:
  - Accepted beat with in_sof=1 and pix_cnt != 0: resynchronise. Data goes to slot 0, pix_cnt -> 1, sof_err -> 1.
  - in_sof=1 with pix_cnt == 0: normal.
  - in_sof=0 with pix_cnt == 0: accepted normally, no error.
- sof_err:
  - Sticky until err_clr=1.
  - If a set and err_clr occur in the same cycle, set wins.
- Reset (async, any state, including mid-fill or mid-send):
  - state=FILL, pix_cnt=0, snd_cnt=0.
  - conv_lin=0, out_vld=0, sof_err=0.
  - in_rdy=1 once rst deasserts.
- No arithmetic beyond counter increment; counters never wrap past their terminal values.

Test Plan:
- Single frame: after reset, stream 36 beats with in_vld=1 continuously, in_data = {p+2*36, p+36, p} (low 8 bits) for p=0..35 -> out_vld high exactly 9 cycles starting the cycle after beat 35. Checks:
  - conv_lin byte (c*36+p) == (c*36+p)&8'hFF for all slots.
  - in_rdy=0 during those 9 cycles.
- Back-to-back: two frames, second beats presented during SEND -> no beat accepted while in_rdy=0. Frame 2 starts filling on cycle 10 after frame 1's last beat, and frame 2 out_vld again lasts 9 cycles.
- Gapped input: in_vld toggles 1/0 randomly over 36 beats -> pix_cnt advances only on handshake; final packing is identical to the gap-free frame.
- SOF resync: send 20 beats, then a beat with in_sof=1 and value 8'hAA on all channels, then 35 more beats -> sof_err=1. Checks:
  - out_vld after the 35th following beat.
  - Slot 0 of each channel == 8'hAA.
  - err_clr=1 for one cycle -> sof_err=0.
- Reset mid-operation: assert rst while in SEND at snd_cnt=4 -> out_vld=0 and conv_lin=0 immediately (async). After release, in_rdy=1, and a full new frame produces a normal 9-cycle out_vld.
- Reset mid-fill: assert rst after beat 17 -> the next frame starts at slot 0. Its out_vld appears only after 36 new beats.
